aes_iter_core: RTL and testbench

- Parametrised iterative AES-128 encryption core. Successor to the single-shot aes block.
- Adds valid/ready handshakes on input and output, so it plugs into streaming datapaths.
- Adds a configurable unroll factor, from 1 to 10 rounds per clock, to trade area against latency.
- Each accepted key/plaintext pair produces exactly one ciphertext. Standard FIPS-197 byte order: byte 0 = bits [127:120].

---
 rtl/aes_pkg.sv | 90 +++++++++
 rtl/aes_round.sv | 19 +
 rtl/aes_iter_core.sv | 128 ++++++++++++
 tb/tb_aes_iter_core.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 primitives shared by the iterative core: S-box, Rcon, round transforms
// and the on-the-fly key-schedule step.
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [127:0] key_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic block_t sub_bytes(input block_t b);
        block_t o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[b[8*i +: 8]];
        return o;
    endfunction

    // Byte n lives at bits [127-8n -: 8]; column c, row r is byte r + 4c.
    function automatic block_t shift_rows(input block_t b);
        block_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = b[127 - 8*(r + 4*((c + r) % 4)) -: 8];
        return o;
    endfunction

    function automatic block_t mix_columns(input block_t b);
        block_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = b[127 - 32*c -: 8];
            a1 = b[119 - 32*c -: 8];
            a2 = b[111 - 32*c -: 8];
            a3 = b[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic key_t key_step(input key_t rk, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = rk[127:96];
        w1 = rk[95:64];
        w2 = rk[63:32];
        w3 = rk[31:0];
        t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rcon, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] rcon_at(input logic [3:0] idx);
        return (idx < 4'd10) ? RCON[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: derives the next round key and applies it.
module aes_round
    import aes_pkg::*;
(
    input  block_t     state,
    input  key_t       rk,
    input  logic [7:0] rcon,
    input  logic       last,
    output block_t     state_n,
    output key_t       rk_n
);

    block_t sr;

    assign rk_n    = key_step(rk, rcon);
    assign sr      = shift_rows(sub_bytes(state));
    assign state_n = (last ? sr : mix_columns(sr)) ^ rk_n;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryptor with valid/ready handshakes and UNROLL rounds per clock.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int NR     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_iter_core: UNROLL must be 1, 2, 5 or 10");
    end
    if (NR != 10) begin : g_bad_nr
        $error("aes_iter_core: NR is fixed at 10 for AES-128");
    end

    localparam logic [3:0] STEP   = 4'(UNROLL);
    localparam logic [3:0] LAST_R = 4'(NR - 1);
    localparam logic [3:0] NR_L   = 4'(NR);

    state_t     state, state_n;
    block_t     st;
    key_t       rk;
    logic [3:0] rcnt, rcnt_n;
    logic       load, step, finish, drain;

    logic [UNROLL:0][127:0] st_c;
    logic [UNROLL:0][127:0] rk_c;

    assign st_c[0] = st;
    assign rk_c[0] = rk;
    assign rcnt_n  = rcnt + STEP;

    // Round j of this clock is absolute round rcnt+j+1, so Rcon follows rcnt, not UNROLL.
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        logic [3:0] ridx;
        assign ridx = rcnt + 4'(j);
        aes_round u_round (
            .state  (st_c[j]),
            .rk     (rk_c[j]),
            .rcon   (rcon_at(ridx)),
            .last   (ridx == LAST_R),
            .state_n(st_c[j+1]),
            .rk_n   (rk_c[j+1])
        );
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        drain    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = en;
                if (en && in_valid) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    step = 1'b1;
                    if (rcnt_n == NR_L) begin
                        finish  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (en && out_ready) begin
                    in_ready = 1'b1;
                    drain    = 1'b1;
                    load     = in_valid;
                    state_n  = in_valid ? RUN : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= '0;
            rk        <= '0;
            rcnt      <= '0;
            cipher    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                st   <= word ^ key;
                rk   <= key;
                rcnt <= '0;
            end else if (step) begin
                st   <= st_c[UNROLL];
                rk   <= rk_c[UNROLL];
                rcnt <= rcnt_n;
            end
            if (finish) begin
                cipher    <= st_c[UNROLL];
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: FIPS-197 vectors, handshake corner cases and a random
// stream checked against a GF(2^8)-arithmetic AES model.
module tb_aes_iter_core;

    logic         clk = 1'b0;
    logic         rst, en, in_valid, out_ready;
    logic [127:0] key, word;
    logic         rdy [4];
    logic         ov  [4];
    logic         bz  [4];
    logic [127:0] ci  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_iter_core #(.UNROLL(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[0]), .key(key), .word(word),
        .out_valid(ov[0]), .out_ready(out_ready), .cipher(ci[0]), .busy(bz[0]));
    aes_iter_core #(.UNROLL(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[1]), .key(key), .word(word),
        .out_valid(ov[1]), .out_ready(out_ready), .cipher(ci[1]), .busy(bz[1]));
    aes_iter_core #(.UNROLL(5)) u5 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[2]), .key(key), .word(word),
        .out_valid(ov[2]), .out_ready(out_ready), .cipher(ci[2]), .busy(bz[2]));
    aes_iter_core #(.UNROLL(10)) u10 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[3]), .key(key), .word(word),
        .out_valid(ov[3]), .out_ready(out_ready), .cipher(ci[3]), .busy(bz[3]));

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (i != 0 && gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            b = inv;
            sb[i] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) u[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[row + 4*c] = u[row + 4*((c + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4*c] = s[row + 4*c] ^ w[4*r + c][31 - 8*row -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (ov[0]) begin
                lat = i;
                break;
            end
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        int           lat;
        int           lats [4];
        logic [127:0] caps [4];
        logic [127:0] k2, w2, exp_c;
        int           unstable, spurious, sent, recv;
        logic         acc;
        logic [127:0] q [$];
        int           un [4];

        un = '{1, 2, 5, 10};
        build_sbox();
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key = '0; word = '0;

        // reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", ov[0], 1'b0);
        chk("rst_cipher",    ci[0], '0);
        chk("rst_busy",      bz[0], 1'b0);
        chk("rst_in_ready",  rdy[0], 1'b1);

        // FIPS-197 C.1 on all unroll factors at once
        key = KC; word = PC; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) lats[i] = -1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            for (int i = 0; i < 4; i++)
                if (ov[i] && lats[i] < 0) begin
                    lats[i] = cyc;
                    caps[i] = ci[i];
                end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("c1_latency_u%0d", un[i]), lats[i], 10 / un[i]);
            chk($sformatf("c1_cipher_u%0d", un[i]), caps[i], CC);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("c1_drain_out_valid", ov[0], 1'b0);

        // FIPS-197 B with 20 cycles of backpressure
        key = KB; word = PB; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_ov(15, lat);
        chk("b_latency", lat, 10);
        chk("b_cipher", ci[0], CB);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ov[0] !== 1'b1 || ci[0] !== CB || rdy[0] !== 1'b0) unstable++;
        end
        chk("bp_hold_stable", unstable, 0);

        // release together with a new block: accepted in the same cycle
        k2 = rand128(); w2 = rand128();
        key = k2; word = w2; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", rdy[0], 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_out_valid_drop", ov[0], 1'b0);
        chk("b2b_busy", bz[0], 1'b1);
        key = rand128(); word = rand128();
        wait_ov(15, lat);
        chk("b2b_latency", lat, 10);
        chk("b2b_cipher", ci[0], aes_ref(k2, w2));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // en gating: request ignored while en low, then a 3-cycle stall mid-RUN
        k2 = rand128(); w2 = rand128();
        key = k2; word = w2; in_valid = 1'b1; en = 1'b0;
        #1;
        chk("en_low_in_ready_idle", rdy[0], 1'b0);
        tick();
        chk("en_low_no_accept", bz[0], 1'b0);
        en = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        en = 1'b0;
        unstable = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (rdy[0] !== 1'b0) unstable++;
            tick();
            if (bz[0] !== 1'b1 || ov[0] !== 1'b0) unstable++;
        end
        chk("en_low_frozen", unstable, 0);
        en = 1'b1;
        wait_ov(15, lat);
        chk("en_latency", (lat < 0) ? -1 : lat + 7, 13);
        chk("en_cipher", ci[0], aes_ref(k2, w2));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset mid-RUN at round 4
        key = rand128(); word = rand128(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", ov[0], 1'b0);
        chk("mid_rst_cipher",    ci[0], '0);
        chk("mid_rst_in_ready",  rdy[0], 1'b1);
        chk("mid_rst_busy",      bz[0], 1'b0);
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ov[0] !== 1'b0) spurious++;
        end
        chk("mid_rst_no_spurious", spurious, 0);

        // random stream with random backpressure
        sent = 0; recv = 0;
        k2 = rand128(); w2 = rand128();
        for (int cyc = 0; cyc < 3000 && recv < 8; cyc++) begin
            in_valid  = (sent < 8);
            key       = k2;
            word      = w2;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid && rdy[0];
            if (acc) begin
                q.push_back(aes_ref(k2, w2));
                sent++;
            end
            if (ov[0] && out_ready) begin
                exp_c = (q.size() > 0) ? q.pop_front() : 128'hx;
                chk($sformatf("stream_cipher_%0d", recv), ci[0], exp_c);
                recv++;
            end
            tick();
            if (acc) begin
                k2 = rand128();
                w2 = rand128();
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("stream_received", recv, 8);
        chk("stream_leftover", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
